// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned DMA_MAX_WAIT_DEF = 8;
  localparam int unsigned DMA_BURST_DEF    = 4;

  typedef enum logic {
    CPU_PRI = 1'b0,
    DMA_PRI = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2,
    TAG_DMA  = 2'd3
  } rsp_tag_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation guard: promotes a refused DMA requester and caps its burst length.
// state   | meaning
// CPU_PRI | dm > if > dma; wait_cnt counts cycles DMA has been refused
// DMA_PRI | dma > dm > if; burst_cnt counts DMA grants since promotion
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned DMA_MAX_WAIT = DMA_MAX_WAIT_DEF,
  parameter int unsigned DMA_BURST    = DMA_BURST_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dma_req_i,
  input  logic       dma_gnt_i,
  output arb_state_e state_o,
  output logic       promote_o,
  output logic       demote_o
);

  localparam int unsigned WAIT_W  = $clog2(DMA_MAX_WAIT + 1);
  localparam int unsigned BURST_W = $clog2(DMA_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(DMA_MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DMA_BURST);

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0] burst_inc;

  always_comb begin
    burst_inc = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
    promote_o = (state_q == CPU_PRI) && dma_req_i && !dma_gnt_i && (wait_cnt_q == WAIT_MAX);
    // Demote on the grant that completes the burst so exactly DMA_BURST grants are given.
    demote_o  = (state_q == DMA_PRI) && (!dma_req_i || (dma_gnt_i && (burst_inc == BURST_MAX)));

    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      CPU_PRI: begin
        burst_cnt_d = '0;
        if (!dma_req_i || dma_gnt_i) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (promote_o) begin
          state_d = DMA_PRI;
        end
      end
      DMA_PRI: begin
        if (demote_o) begin
          state_d     = CPU_PRI;
          wait_cnt_d  = '0;
          burst_cnt_d = '0;
        end else if (dma_gnt_i) begin
          wait_cnt_d  = '0;
          burst_cnt_d = burst_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU fetch, CPU data and DMA with one-cycle
// read return routed by a registered response tag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned DMA_MAX_WAIT = DMA_MAX_WAIT_DEF,
  parameter int unsigned DMA_BURST    = DMA_BURST_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,

  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,

  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,

  output logic [DATA_W-1:0] rdata_o,
  output logic              cpu_stall_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-2:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e arb_state;
  logic       promote, demote;
  rsp_tag_e   tag_q, tag_d;
  logic       arb_unused;

  mem_arb_starve #(
    .DMA_MAX_WAIT (DMA_MAX_WAIT),
    .DMA_BURST    (DMA_BURST)
  ) u_starve (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .dma_req_i (dma_req_i),
    .dma_gnt_i (dma_gnt_o),
    .state_o   (arb_state),
    .promote_o (promote),
    .demote_o  (demote)
  );

  // Byte-address bit 0 has no meaning for a word memory; promote/demote are
  // already folded into the state register.
  assign arb_unused = ^{if_addr_i[0], dm_addr_i[0], dma_addr_i[0], promote, demote};

  always_comb begin
    if_gnt_o  = 1'b0;
    dm_gnt_o  = 1'b0;
    dma_gnt_o = 1'b0;
    if (!rst_i) begin
      if (arb_state == DMA_PRI) begin
        if (dma_req_i)     dma_gnt_o = 1'b1;
        else if (dm_req_i) dm_gnt_o  = 1'b1;
        else if (if_req_i) if_gnt_o  = 1'b1;
      end else begin
        // Data before fetch keeps a load/store ahead of the next instruction.
        if (dm_req_i)       dm_gnt_o  = 1'b1;
        else if (if_req_i)  if_gnt_o  = 1'b1;
        else if (dma_req_i) dma_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = if_gnt_o | dm_gnt_o | dma_gnt_o;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    tag_d       = TAG_NONE;
    if (dma_gnt_o) begin
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i[ADDR_W-1:1];
      mem_wdata_o = dma_wdata_i;
      if (!dma_we_i) tag_d = TAG_DMA;
    end else if (dm_gnt_o) begin
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i[ADDR_W-1:1];
      mem_wdata_o = dm_wdata_i;
      if (!dm_we_i) tag_d = TAG_DM;
    end else if (if_gnt_o) begin
      mem_addr_o  = if_addr_i[ADDR_W-1:1];
      tag_d       = TAG_IF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // A reset arriving while a read is in flight swallows its response.
  assign if_rvalid_o  = (tag_q == TAG_IF)  && !rst_i;
  assign dm_rvalid_o  = (tag_q == TAG_DM)  && !rst_i;
  assign dma_rvalid_o = (tag_q == TAG_DMA) && !rst_i;
  assign rdata_o      = mem_rdata_i;

  assign cpu_stall_o = (if_req_i & ~if_gnt_o) | (dm_req_i & ~dm_gnt_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level priority/starvation model and a shadow memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int MAXW  = 8;
  localparam int BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt, dm_rvalid;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] rdata;
  logic          cpu_stall, mem_en, mem_we;
  logic [AW-2:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DMA_MAX_WAIT(MAXW), .DMA_BURST(BURST)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid),
    .rdata_o(rdata), .cpu_stall_o(cpu_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory device (64 words), with a preload path used only during reset.
  logic [DW-1:0] dev_mem [0:63];
  logic          pl_en;
  logic [5:0]    pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) dev_mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) dev_mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= dev_mem[mem_addr[5:0]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: priority mode, elapsed DMA wait, grants in current burst,
  // pending read (-1 none, else port 0=if 1=dm 2=dma) and shadow memory.
  bit            m_dma;
  int            m_wait, m_burst, m_tag;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:63];

  logic [2:0]    last_g, last_rv;
  logic          last_stall;
  logic [AW-2:0] last_maddr;
  logic [DW-1:0] last_rdata;

  function automatic int pick(input bit dmode, input logic r_if, input logic r_dm, input logic r_dma);
    int   order[3];
    logic req[3];
    int   win;
    req[0] = r_if; req[1] = r_dm; req[2] = r_dma;
    if (dmode) order = '{2, 1, 0};
    else       order = '{1, 0, 2};
    win = -1;
    for (int k = 0; k < 3; k++)
      if (win < 0 && req[order[k]]) win = order[k];
    return win;
  endfunction

  task automatic step();
    int            w;
    logic [2:0]    exp_g, exp_rv;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    w = rst ? -1 : pick(m_dma, if_req, dm_req, dma_req);
    exp_g  = (w < 0) ? 3'b000 : 3'(1 << w);
    e_addr = '0; e_we = 1'b0; e_wd = '0;
    case (w)
      0: e_addr = if_addr;
      1: begin e_addr = dm_addr;  e_we = dm_we;  e_wd = dm_wdata;  end
      2: begin e_addr = dma_addr; e_we = dma_we; e_wd = dma_wdata; end
      default: ;
    endcase
    check_val("gnt", {29'd0, dma_gnt, dm_gnt, if_gnt}, {29'd0, exp_g});
    check_val("mem_en", {31'd0, mem_en}, {31'd0, (w >= 0)});
    check_val("cpu_stall", {31'd0, cpu_stall}, {31'd0, (if_req && w != 0) || (dm_req && w != 1)});
    check_val("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    if (w >= 0) check_val("mem_addr", {17'd0, mem_addr}, {17'd0, e_addr[AW-1:1]});
    if (e_we)   check_val("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wd});
    exp_rv = (rst || m_tag < 0) ? 3'b000 : 3'(1 << m_tag);
    check_val("rvalid", {29'd0, dma_rvalid, dm_rvalid, if_rvalid}, {29'd0, exp_rv});
    if (exp_rv != 3'b000) check_val("rdata", {16'd0, rdata}, {16'd0, m_rdata});
    check_val("state", {31'd0, dut.u_starve.state_q}, {31'd0, m_dma});
    last_g     = {dma_gnt, dm_gnt, if_gnt};
    last_rv    = {dma_rvalid, dm_rvalid, if_rvalid};
    last_stall = cpu_stall;
    last_maddr = mem_addr;
    last_rdata = rdata;
    @(posedge clk);
    if (rst) begin
      m_dma = 0; m_wait = 0; m_burst = 0; m_tag = -1;
    end else begin
      m_tag = -1;
      if (w >= 0) begin
        if (e_we) ref_mem[e_addr[6:1]] = e_wd;
        else begin m_tag = w; m_rdata = ref_mem[e_addr[6:1]]; end
      end
      if (!m_dma) begin
        if (dma_req && w != 2) begin
          if (m_wait == MAXW) begin m_dma = 1; m_burst = 0; end
          else m_wait++;
        end else m_wait = 0;
      end else if (!dma_req) begin
        m_dma = 0; m_wait = 0; m_burst = 0;
      end else begin
        m_wait = 0;
        m_burst++;
        if (m_burst == BURST) begin m_dma = 0; m_burst = 0; end
      end
    end
    #1;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a[5:0]; pl_data = d;
    step();
    ref_mem[a] = d;
    pl_en = 1'b0;
  endtask

  int first_dma, n_dma, resume, stall_dma;

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    m_dma = 0; m_wait = 0; m_burst = 0; m_tag = -1; m_rdata = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) preload(i, 16'($urandom));
    preload(8, 16'hBEEF);
    rst = 1'b0;

    // Reset then idle
    step();
    check_val("rst_wait_cnt", 32'(dut.u_starve.wait_cnt_q), 32'd0);
    check_val("rst_burst_cnt", 32'(dut.u_starve.burst_cnt_q), 32'd0);
    check_val("idle_stall", {31'd0, last_stall}, 32'd0);

    // Fetch alone from 0x0010
    if_req = 1; if_addr = 16'h0010;
    step();
    check_val("if_gnt_alone", {29'd0, last_g}, 32'd1);
    check_val("if_word_addr", {17'd0, last_maddr}, 32'd8);
    if_req = 0;
    step();
    check_val("if_rvalid_alone", {29'd0, last_rv}, 32'd1);
    check_val("if_rdata_beef", {16'd0, last_rdata}, 32'hBEEF);

    // Fetch and data read together
    if_req = 1; if_addr = 16'h0030; dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
    step();
    check_val("dm_wins", {29'd0, last_g}, 32'd2);
    check_val("fetch_stalled", {31'd0, last_stall}, 32'd1);
    dm_req = 0;
    step();
    check_val("dm_rv_if_gnt", {26'd0, last_rv, last_g}, {26'd0, 3'b010, 3'b001});
    if_req = 0;
    step();
    check_val("if_rv_after", {29'd0, last_rv}, 32'd1);

    // Write then read back
    dm_req = 1; dm_we = 1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    step();
    check_val("dm_wr_gnt", {29'd0, last_g}, 32'd2);
    dm_we = 0;
    step();
    check_val("dm_wr_no_rv", {29'd0, last_rv}, 32'd0);
    dm_req = 0;
    step();
    check_val("dm_rd_rv", {29'd0, last_rv}, 32'd2);
    check_val("dm_rd_data", {16'd0, last_rdata}, 32'h1234);

    // DMA starvation guard against a continuous fetch stream
    first_dma = -1; n_dma = 0; resume = -1; stall_dma = 0;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0050; if_req = 1; if_addr = 16'h0012;
    for (int c = 0; c < 20; c++) begin
      step();
      if (last_g[2]) begin
        if (first_dma < 0) first_dma = c;
        n_dma++;
        if (last_stall) stall_dma++;
      end else if (last_g[0] && first_dma >= 0 && resume < 0) resume = c;
    end
    check_val("dma_first_gnt", 32'(first_dma), 32'd9);
    check_val("dma_burst_len", 32'(n_dma), 32'd4);
    check_val("dma_burst_stall", 32'(stall_dma), 32'd4);
    check_val("fetch_resume", 32'(resume), 32'd13);
    dma_req = 0; if_req = 0;
    step();
    step();

    // Reset during an outstanding read
    dm_req = 1; dm_we = 0; dm_addr = 16'h0022; dma_req = 1; dma_addr = 16'h0060;
    for (int c = 0; c < 4; c++) step();
    check_val("wait_cnt_grows", 32'(dut.u_starve.wait_cnt_q), 32'd4);
    rst = 1;
    step();
    check_val("rst_drops_rv", {29'd0, last_rv}, 32'd0);
    check_val("rst_gnt_zero", {29'd0, last_g}, 32'd0);
    check_val("rst2_wait_cnt", 32'(dut.u_starve.wait_cnt_q), 32'd0);
    check_val("rst2_burst_cnt", 32'(dut.u_starve.burst_cnt_q), 32'd0);
    rst = 0; dm_req = 0; dma_req = 0;
    step();
    check_val("post_rst_rv", {29'd0, last_rv}, 32'd0);

    // Random traffic honoring hold-until-grant
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (!if_req || last_g[0]) begin
        if_req = ($urandom_range(0, 9) < 6); if_addr = 16'($urandom_range(0, 127));
      end else if ($urandom_range(0, 19) == 0) if_req = 0;
      if (!dm_req || last_g[1]) begin
        dm_req = ($urandom_range(0, 9) < 6); dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 127)); dm_wdata = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) dm_req = 0;
      if (!dma_req || last_g[2]) begin
        dma_req = ($urandom_range(0, 9) < 5); dma_we = 1'($urandom_range(0, 1));
        dma_addr = 16'($urandom_range(0, 127)); dma_wdata = 16'($urandom);
      end else if ($urandom_range(0, 29) == 0) dma_req = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-ported, word-organised synchronous memory between three requesters: the CPU instruction-fetch port, the CPU data port and a DMA/loader port. It replaces the separate instruction and data memories with a unified memory. It issues at most one access per cycle and routes read data back to the originator one cycle later. It raises a stall to the CPU whenever a CPU request is not granted. A starvation counter bounds DMA waiting, and a bounded DMA burst mode bounds CPU waiting.

## Interface
- ADDR_W, 16: requester byte-address width.
- DATA_W, 16: data word width.
- DMA_MAX_WAIT, 8: consecutive cycles DMA may wait while requesting before it is promoted.
- DMA_BURST, 4: maximum consecutive DMA grants once promoted.
- clk  in  1  single clock. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (always a read).
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid on rdata.
- dm_req, dm_we  in  1 each  data request / write enable.
- dm_addr  in  ADDR_W  data byte address. dm_wdata  in  DATA_W  data write data.
- dm_gnt, dm_rvalid  out  1 each  data accepted / read data valid.
- dma_req, dma_we  in  1 each. dma_addr  in  ADDR_W. dma_wdata  in  DATA_W.
- dma_gnt, dma_rvalid  out  1 each.
- rdata  out  DATA_W  shared read-return bus.
- cpu_stall  out  1  a CPU request is pending and not granted.
- mem_en, mem_we  out  1 each  memory strobe / write.
- mem_addr  out  ADDR_W-1  word address. mem_wdata  out  DATA_W.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

## Operation
- Requesters hold req, addr, we and wdata stable until they see gnt. A gnt high means the access is issued in that same cycle.
- mem_addr = addr[ADDR_W-1:1]. Bit 0 is ignored and no alignment fault is raised.
- At most one gnt per cycle. mem_en = OR of the gnts. The mem_* fields are copied from the winner. With no winner, mem_we=0 and the other fields hold don't-care values.
- FSM has two states:
  - CPU_PRI (reset state): priority is dm > if > dma.
  - DMA_PRI: priority is dma > dm > if.
- wait_cnt behaviour:
  - Increments while in CPU_PRI with dma_req=1 and dma_gnt=0.
  - Clears whenever dma_gnt=1 or dma_req=0.
  - When wait_cnt reaches DMA_MAX_WAIT, the next state is DMA_PRI.
- burst_cnt behaviour:
  - Clears on entry to DMA_PRI and increments on each dma_gnt there.
  - DMA_PRI returns to CPU_PRI when dma_req=0 or burst_cnt reaches DMA_BURST. On return, wait_cnt is cleared.
- Response tag is registered each cycle:
  - Holds {IF, DM, DMA} for a read grant.
  - Holds NONE for a write or no grant.
  - Next cycle, the matching x_rvalid pulses for one cycle and rdata = mem_rdata.
  - Writes get no rvalid; gnt is their completion.
- cpu_stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt). It is combinational.
- A data access and a fetch requested together: the data access wins and the fetch stalls one cycle. This keeps load/store ordering ahead of the next instruction.

## Timing
- Grant path is combinational from req and state, with zero-cycle acceptance. State, counters and tag are registered.
- Read latency is 1 cycle from gnt to rvalid. Back-to-back reads from any mix of ports sustain one issue per cycle.
- Reset values:
  - State CPU_PRI, wait_cnt=0, burst_cnt=0, tag NONE.
  - All rvalid=0 in the cycle after rst.
  - Gnts and mem_en=0 while rst=1. cpu_stall follows its equation except that gnts are forced 0.
- Reset during an outstanding read drops the response; no rvalid is issued.
- A requester that drops req without a gnt is legal and changes nothing except wait_cnt clearing (DMA only).
- Bounds:
  - Worst-case DMA wait is DMA_MAX_WAIT+1 cycles.
  - Worst-case CPU stall caused by DMA is DMA_BURST cycles.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.

## Structure
- Package mem_arb_pkg holds:
  - State enum {CPU_PRI, DMA_PRI}.
  - Tag enum {TAG_NONE, TAG_IF, TAG_DM, TAG_DMA}.
  - Default parameter constants.
- One sub-module, mem_arb_starve: wait_cnt, burst_cnt and the state register, with promote and demote outputs.
- The priority mux, tag register and return routing stay in mem_arbiter.

## Test plan
- Reset then idle: all gnt/rvalid/mem_en=0, cpu_stall=0, state CPU_PRI.
- if_req alone at 0x0010 with memory word 8=0xBEEF -> if_gnt same cycle, mem_addr=8, next cycle if_rvalid=1 and rdata=0xBEEF.
- if_req and dm_req (read 0x0020) together -> dm_gnt, cpu_stall=1. Next cycle dm_rvalid plus if_gnt. The cycle after, if_rvalid.
- dm write 0x1234 to 0x0040, then dm read of 0x0040 -> dm_gnt on both. Read returns 0x1234 with no rvalid on the write.
- dma_req held with if_req held continuously, DMA_MAX_WAIT=8, DMA_BURST=4:
  - dma_gnt first asserts on cycle 9.
  - It holds for 4 cycles with cpu_stall=1.
  - Fetch resumes on cycle 13.
- Read granted, rst asserted the next cycle -> no rvalid pulse, counters 0, state CPU_PRI.
